// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and access sequencer for the unified RAM
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic [31:0] f_rdata,
    output logic        f_done,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_data_out,
    output logic        busy,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // The counter is loaded with WAIT_CYCLES-1 so that zero marks the final access edge.
    localparam logic [3:0] CNT_LOAD   = 4'(WAIT_CYCLES - 1);
    localparam logic       PORT_FETCH = 1'b0;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic        r_last_grant;
    logic        r_port;
    logic        r_write;
    logic [31:0] r_f_rdata;
    logic [31:0] r_d_rdata;
    logic        r_f_done;
    logic        r_d_done;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_data_in;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_addr_err;

    logic        w_grant;
    logic        w_grant_data;
    logic        w_grant_write;
    logic        w_in_range;
    logic        w_final;
    logic [31:0] w_sel_addr;

    // Arbitration, range check and next-state decode
    always_comb begin
        w_next_state  = r_state;
        w_grant       = 1'b0;
        w_grant_data  = 1'b0;
        w_grant_write = 1'b0;
        w_sel_addr    = f_addr;
        w_in_range    = 1'b0;
        w_final       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (f_req || d_req) begin
                    w_grant       = 1'b1;
                    // On a tie the port that did not win last time is served.
                    w_grant_data  = d_req && (!f_req || (r_last_grant == PORT_FETCH));
                    w_grant_write = w_grant_data && d_write;
                    w_sel_addr    = w_grant_data ? d_addr : f_addr;
                    w_in_range    = ((w_sel_addr >> ADDR_WIDTH) == 32'd0);
                    w_next_state  = w_in_range ? S_ACCESS : S_DONE;
                end
            end
            S_ACCESS: begin
                w_final = (r_cnt == 4'd0);
                if (w_final) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request latching, RAM drive, read-data capture and completion pulses
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_cnt         <= 4'd0;
            r_last_grant  <= PORT_FETCH;
            r_port        <= PORT_FETCH;
            r_write       <= 1'b0;
            r_f_rdata     <= 32'd0;
            r_d_rdata     <= 32'd0;
            r_f_done      <= 1'b0;
            r_d_done      <= 1'b0;
            r_mem_address <= 32'd0;
            r_mem_data_in <= 32'd0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_addr_err    <= 1'b0;
        end else begin
            r_f_done   <= 1'b0;
            r_d_done   <= 1'b0;
            r_addr_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_port  <= w_grant_data;
                        r_write <= w_grant_write;
                        if (w_in_range) begin
                            r_mem_address <= w_sel_addr;
                            r_mem_data_in <= w_grant_data ? d_wdata : 32'd0;
                            r_mem_read    <= !w_grant_write;
                            r_mem_write   <= w_grant_write;
                            r_cnt         <= CNT_LOAD;
                        end else begin
                            // Out-of-range requests complete at once and never touch the RAM.
                            r_addr_err <= 1'b1;
                            if (w_grant_data) begin
                                r_d_done  <= 1'b1;
                                r_d_rdata <= 32'd0;
                            end else begin
                                r_f_done  <= 1'b1;
                                r_f_rdata <= 32'd0;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_final) begin
                        if (r_port == PORT_FETCH) begin
                            r_f_done  <= 1'b1;
                            r_f_rdata <= r_write ? 32'd0 : mem_data_out;
                        end else begin
                            r_d_done  <= 1'b1;
                            r_d_rdata <= r_write ? 32'd0 : mem_data_out;
                        end
                        r_mem_address <= 32'd0;
                        r_mem_data_in <= 32'd0;
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_port;
                end
                default: begin
                    r_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign f_rdata     = r_f_rdata;
    assign f_done      = r_f_done;
    assign d_rdata     = r_d_rdata;
    assign d_done      = r_d_done;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign busy        = (r_state != S_IDLE);
    assign addr_err    = r_addr_err;

endmodule
